// File: rtl/pulse_width_meter.sv
// Pulse width meter: synchronizes pulse_i and times each high interval.
// Completed widths are held on a valid/ready result port until consumed.
module pulse_width_meter #(
  parameter int MAX_CYCLES  = 1023,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 1,
  localparam int W = $clog2(MAX_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_i,
  input  logic         enable,
  output logic [W-1:0] width_o,
  output logic         overflow_o,
  output logic         width_valid_o,
  input  logic         width_ready_i,
  output logic         busy_o,
  output logic         drop_o,
  output logic         glitch_o
);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   s, s_d;
  logic                   rise, fall;
  logic [W-1:0]           cnt;
  logic                   ovf_acc;
  logic                   done, keep, short_p, load;
  logic                   valid_n;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // fill_q marks when the chain holds real samples rather than reset zeros,
  // so a level held high through reset is not mistaken for a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = ARM;
    end else begin
      unique case (state)
        ARM:     if (fill_q[SYNC_STAGES-1] && !s) state_n = IDLE;
        IDLE:    if (rise) state_n = MEASURE;
        MEASURE: if (fall) state_n = IDLE;
        default: state_n = ARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (state == IDLE && state_n == MEASURE) begin
      cnt     <= W'(1);
      ovf_acc <= 1'b0;
    end else if (enable && state == MEASURE && s) begin
      if (cnt == W'(MAX_CYCLES)) ovf_acc <= 1'b1;
      else                       cnt     <= cnt + W'(1);
    end
  end

  always_comb begin
    done    = enable && (state == MEASURE) && fall;
    keep    = done && (cnt >= W'(MIN_WIDTH));
    short_p = done && !keep;
    load    = keep && (!width_valid_o || width_ready_i);
    valid_n = load || (width_valid_o && !width_ready_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_o       <= '0;
      overflow_o    <= 1'b0;
      width_valid_o <= 1'b0;
      drop_o        <= 1'b0;
      glitch_o      <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      if (load) begin
        width_o    <= cnt;
        overflow_o <= ovf_acc;
      end
      width_valid_o <= valid_n;
      drop_o        <= keep && !load;
      glitch_o      <= short_p;
      busy_o        <= (state_n == MEASURE);
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: directed scenarios plus random pulse
// trains checked against a run-length reference model.
module tb_pulse_width_meter;

  localparam int MAXC = 15;
  localparam int SYNC = 2;
  localparam int MINW = 3;
  localparam int W    = $clog2(MAXC + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pulse_i = 1'b0;
  logic         enable = 1'b1;
  logic [W-1:0] width_o;
  logic         overflow_o;
  logic         width_valid_o;
  logic         width_ready_i = 1'b1;
  logic         busy_o;
  logic         drop_o;
  logic         glitch_o;

  int errs = 0;
  int checks = 0;
  bit evt_seen = 0;
  bit model_on = 0;

  int ecnt = 0;
  int run = 0;
  int q_due[$];
  int q_w[$];
  bit mvalid = 0;
  int mwidth = 0;
  bit movf = 0;
  bit e_glitch = 0;
  bit e_drop = 0;

  pulse_width_meter #(
    .MAX_CYCLES (MAXC),
    .SYNC_STAGES(SYNC),
    .MIN_WIDTH  (MINW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_i      (pulse_i),
    .enable       (enable),
    .width_o      (width_o),
    .overflow_o   (overflow_o),
    .width_valid_o(width_valid_o),
    .width_ready_i(width_ready_i),
    .busy_o       (busy_o),
    .drop_o       (drop_o),
    .glitch_o     (glitch_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each high run of N samples ends at the first low sample;
  // SYNC edges later it yields a glitch or a width min(N,MAXC).
  task automatic model_step(input bit p, input bit r);
    bit xfer;
    bit loaded;
    int w;
    ecnt++;
    e_glitch = 0;
    e_drop = 0;
    loaded = 0;
    xfer = mvalid && r;
    if (q_due.size() > 0 && q_due[0] == ecnt) begin
      void'(q_due.pop_front());
      w = q_w.pop_front();
      if (w < MINW) e_glitch = 1;
      else if (!mvalid || r) begin
        mvalid = 1;
        mwidth = (w > MAXC) ? MAXC : w;
        movf = (w > MAXC);
        loaded = 1;
      end else e_drop = 1;
    end
    if (!loaded && xfer) mvalid = 0;
    if (p) run++;
    else if (run > 0) begin
      q_due.push_back(ecnt + SYNC);
      q_w.push_back(run);
      run = 0;
    end
  endtask

  task automatic cyc(input bit p, input bit r);
    logic [31:0] got_v, exp_v;
    pulse_i = p;
    width_ready_i = r;
    @(posedge clk);
    if (model_on) model_step(p, r);
    #1;
    if (width_valid_o || glitch_o || drop_o) evt_seen = 1;
    if (model_on) begin
      got_v = '0;
      exp_v = '0;
      got_v[3:0] = {width_valid_o, width_valid_o & overflow_o,
                    glitch_o, drop_o};
      if (width_valid_o) got_v[4 +: W] = width_o;
      exp_v[3:0] = {mvalid, mvalid & movf, e_glitch, e_drop};
      if (mvalid) exp_v[4 +: W] = W'(mwidth);
      check("model", got_v, exp_v);
    end
  endtask

  task automatic hi(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b1, r);
  endtask

  task automatic lo(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, r);
  endtask

  initial begin
    cyc(0, 1);
    cyc(0, 1);
    check("rst_out", {width_o, overflow_o, width_valid_o,
                      busy_o, drop_o, glitch_o}, '0);
    rst_n = 1'b1;
    lo(6, 1);

    // basic 10-cycle pulse
    cyc(1, 1);
    cyc(1, 1);
    check("busy_early", busy_o, 0);
    cyc(1, 1);
    check("busy_rise", busy_o, 1);
    hi(7, 1);
    lo(2, 1);
    check("basic_lat", width_valid_o, 0);
    cyc(0, 1);
    check("basic_vld", width_valid_o, 1);
    check("basic_w", width_o, 10);
    check("basic_ovf", overflow_o, 0);
    cyc(0, 1);
    check("basic_clr", width_valid_o, 0);
    check("busy_fall", busy_o, 0);
    lo(2, 1);

    // saturation
    hi(15, 1);
    lo(3, 1);
    check("sat15_w", width_o, 15);
    check("sat15_ovf", {width_valid_o, overflow_o}, 2'b10);
    lo(3, 1);
    hi(40, 1);
    lo(3, 1);
    check("sat40_w", width_o, 15);
    check("sat40_ovf", {width_valid_o, overflow_o}, 2'b11);
    lo(3, 1);

    // backpressure
    hi(5, 0);
    lo(3, 0);
    check("bp_first", {width_valid_o, width_o}, {1'b1, W'(5)});
    lo(2, 0);
    hi(7, 0);
    lo(2, 0);
    check("bp_nodrop", drop_o, 0);
    cyc(0, 0);
    check("bp_drop", {drop_o, width_valid_o, width_o}, {2'b11, W'(5)});
    cyc(0, 0);
    check("bp_drop1", {drop_o, width_o}, {1'b0, W'(5)});
    cyc(0, 1);
    check("bp_clr", width_valid_o, 0);
    lo(2, 1);

    // transfer and completion on the same edge
    hi(5, 0);
    lo(3, 0);
    check("sim_first", {width_valid_o, width_o}, {1'b1, W'(5)});
    lo(2, 0);
    hi(7, 0);
    lo(2, 0);
    cyc(0, 1);
    check("sim_load", {width_valid_o, drop_o, width_o}, {2'b10, W'(7)});
    cyc(0, 1);
    check("sim_clr", width_valid_o, 0);
    lo(2, 1);

    // glitch filter
    hi(2, 1);
    lo(2, 1);
    check("gl_early", glitch_o, 0);
    cyc(0, 1);
    check("gl_pulse", {glitch_o, width_valid_o}, 2'b10);
    cyc(0, 1);
    check("gl_one", glitch_o, 0);
    hi(3, 1);
    lo(3, 1);
    check("gl_min", {width_valid_o, width_o}, {1'b1, W'(3)});
    lo(3, 1);

    // level held high through reset release
    rst_n = 1'b0;
    cyc(1, 1);
    cyc(1, 1);
    rst_n = 1'b1;
    evt_seen = 0;
    hi(10, 1);
    lo(5, 1);
    check("arm_rst", evt_seen, 0);
    hi(8, 1);
    lo(3, 1);
    check("arm_rst_8", {width_valid_o, width_o}, {1'b1, W'(8)});
    lo(3, 1);

    // enable dropped mid-pulse
    evt_seen = 0;
    hi(4, 1);
    enable = 1'b0;
    cyc(1, 1);
    check("en_busy", busy_o, 0);
    hi(2, 1);
    lo(3, 1);
    enable = 1'b1;
    lo(4, 1);
    check("arm_en", evt_seen, 0);
    hi(8, 1);
    lo(3, 1);
    check("arm_en_8", {width_valid_o, width_o}, {1'b1, W'(8)});
    lo(4, 1);

    // random pulse trains with random backpressure
    run = 0;
    mvalid = 0;
    q_due.delete();
    q_w.delete();
    model_on = 1;
    for (int k = 0; k < 60; k++) begin
      int len, gap;
      len = $urandom_range(1, 20);
      gap = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) cyc(1, $urandom_range(0, 3) != 0);
      for (int i = 0; i < gap; i++) cyc(0, $urandom_range(0, 3) != 0);
    end
    lo(8, 1);
    model_on = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
